// File: rtl/lif_neuron_unit.sv
// Leaky integrate-and-fire neuron fed by the channel adder tree; one leak/fire decision per step_tick.
// Optional LIF_SPIKE_CNT_EN adds a saturating 16-bit spike_count output.
module lif_neuron_unit #(
  parameter int IN_W         = 8,
  parameter int MEM_W        = 16,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sum_valid,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             step_tick,
  input  logic [MEM_W-1:0] threshold,
  output logic             spike_out,
  output logic             spike_valid,
  output logic [MEM_W-1:0] membrane,
  output logic             refractory
`ifdef LIF_SPIKE_CNT_EN
  ,
  output logic [15:0]      spike_count
`endif
);

  localparam int CNT_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  typedef enum logic {INTEG = 1'b0, REFRAC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0] mem_q, mem_d;
  logic             spike_q, spike_d;
  logic             spike_valid_q;

  logic [MEM_W-1:0] addend;
  logic [MEM_W:0]   raw_sum;
  logic [MEM_W-1:0] v_int;
  logic [MEM_W-1:0] v_leak;

  // Saturating integrate of the (zero-extended) input into the membrane.
  always_comb begin
    addend  = sum_valid ? MEM_W'(sum_in) : '0;
    raw_sum = {1'b0, mem_q} + {1'b0, addend};
    v_int   = raw_sum[MEM_W] ? '1 : raw_sum[MEM_W-1:0];
    v_leak  = v_int - (v_int >> LEAK_SHIFT);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    spike_d = spike_q;
    case (state_q)
      INTEG: begin
        if (step_tick) begin
          if (v_int >= threshold) begin
            spike_d = 1'b1;
            mem_d   = '0;
            if (REFRAC_STEPS > 0) begin
              state_d = REFRAC;
              cnt_d   = CNT_W'(REFRAC_STEPS);
            end
          end else begin
            spike_d = 1'b0;
            mem_d   = v_leak;
          end
        end else if (sum_valid) begin
          mem_d = v_int;
        end
      end
      REFRAC: begin
        // Input is dropped while refractory; the tick that empties the counter releases the state.
        mem_d = '0;
        if (step_tick) begin
          spike_d = 1'b0;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = INTEG;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = INTEG;
        cnt_d   = '0;
        mem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= INTEG;
      cnt_q         <= '0;
      mem_q         <= '0;
      spike_q       <= 1'b0;
      spike_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      spike_q       <= spike_d;
      spike_valid_q <= step_tick;
    end
  end

  assign spike_out   = spike_q;
  assign spike_valid = spike_valid_q;
  assign membrane    = mem_q;
  assign refractory  = (state_q == REFRAC);

`ifdef LIF_SPIKE_CNT_EN
  logic [15:0] spike_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      spike_cnt_q <= '0;
    end else if (spike_valid_q && spike_q && (spike_cnt_q != 16'hFFFF)) begin
      spike_cnt_q <= spike_cnt_q + 16'd1;
    end
  end

  assign spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_lif_neuron_unit.sv
// Randomized self-checking bench for lif_neuron_unit against an integer reference model.
// Also covers the directed integrate/leak/fire/refractory/saturation/reset scenarios.
module tb_lif_neuron_unit;

  localparam int IN_W         = 8;
  localparam int MEM_W        = 16;
  localparam int LEAK_SHIFT   = 3;
  localparam int REFRAC_STEPS = 2;
  localparam int MEM_MAX      = (1 << MEM_W) - 1;

  logic             clk;
  logic             nrst;
  logic             sum_valid;
  logic [IN_W-1:0]  sum_in;
  logic             step_tick;
  logic [MEM_W-1:0] threshold;
  logic             spike_out;
  logic             spike_valid;
  logic [MEM_W-1:0] membrane;
  logic             refractory;
`ifdef LIF_SPIKE_CNT_EN
  logic [15:0]      spike_count;
`endif

  lif_neuron_unit #(
    .IN_W(IN_W), .MEM_W(MEM_W), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC_STEPS(REFRAC_STEPS)
  ) dut (
    .clk(clk), .nrst(nrst), .sum_valid(sum_valid), .sum_in(sum_in),
    .step_tick(step_tick), .threshold(threshold), .spike_out(spike_out),
    .spike_valid(spike_valid), .membrane(membrane), .refractory(refractory)
`ifdef LIF_SPIKE_CNT_EN
    , .spike_count(spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers, "steps left in refractory" instead of a state machine.
  int m_mem, m_left, m_spike, m_sv, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mem = 0; m_left = 0; m_spike = 0; m_sv = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input int v, input int s, input int t, input int th);
    int vint;
    if (m_sv == 1 && m_spike == 1 && m_cnt < 65535) m_cnt++;
    m_sv = t;
    if (m_left == 0) begin
      if (t != 0) begin
        vint = m_mem + (v != 0 ? s : 0);
        if (vint > MEM_MAX) vint = MEM_MAX;
        if (vint >= th) begin
          m_spike = 1;
          m_mem   = 0;
          m_left  = REFRAC_STEPS;
        end else begin
          m_spike = 0;
          m_mem   = vint - vint / (1 << LEAK_SHIFT);
        end
      end else if (v != 0) begin
        m_mem = m_mem + s;
        if (m_mem > MEM_MAX) m_mem = MEM_MAX;
      end
    end else begin
      m_mem = 0;
      if (t != 0) begin
        m_spike = 0;
        m_left--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".membrane"}, 32'(membrane), 32'(m_mem));
    check_eq({tag, ".spike_valid"}, 32'(spike_valid), 32'(m_sv));
    check_eq({tag, ".refractory"}, 32'(refractory), (m_left > 0) ? 32'd1 : 32'd0);
    if (m_sv == 1) check_eq({tag, ".spike_out"}, 32'(spike_out), 32'(m_spike));
`ifdef LIF_SPIKE_CNT_EN
    check_eq({tag, ".spike_count"}, 32'(spike_count), 32'(m_cnt));
`endif
  endtask

  // Called at a negedge: drive inputs, advance the model over the next posedge, check at next negedge.
  task automatic cycle(input string tag, input int v, input int s, input int t, input int th);
    sum_valid = v[0];
    sum_in    = s[IN_W-1:0];
    step_tick = t[0];
    threshold = th[MEM_W-1:0];
    model_edge(v, s, t, th);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    sum_valid = 1'b0; step_tick = 1'b0; sum_in = '0;
    #2 nrst = 1'b0;
    #1;
    check_eq({tag, ".rst_membrane"}, 32'(membrane), 32'd0);
    check_eq({tag, ".rst_spike_out"}, 32'(spike_out), 32'd0);
    check_eq({tag, ".rst_spike_valid"}, 32'(spike_valid), 32'd0);
    check_eq({tag, ".rst_refractory"}, 32'(refractory), 32'd0);
`ifdef LIF_SPIKE_CNT_EN
    check_eq({tag, ".rst_spike_count"}, 32'(spike_count), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0; sum_valid = 1'b0; sum_in = '0; step_tick = 1'b0; threshold = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    nrst = 1'b1;

    // Integrate and leak: 40 + 40 = 80, tick leaks 80 -> 70.
    cycle("int1", 1, 40, 0, 100);
    cycle("int2", 1, 40, 0, 100);
    check_eq("int.mem80", 32'(membrane), 32'd80);
    cycle("leak", 0, 0, 1, 100);
    check_eq("leak.mem70", 32'(membrane), 32'd70);
    check_eq("leak.nospike", 32'(spike_out), 32'd0);
    // Same-cycle input pushes 70 + 30 to the threshold.
    cycle("fire", 1, 30, 1, 100);
    check_eq("fire.spike", 32'(spike_out), 32'd1);
    check_eq("fire.refr", 32'(refractory), 32'd1);
    cycle("refr_drop", 1, 50, 0, 100);
    check_eq("refr.mem0", 32'(membrane), 32'd0);
    cycle("refr_t1", 0, 0, 1, 100);
    check_eq("refr_t1.refr", 32'(refractory), 32'd1);
    cycle("refr_t2", 0, 0, 1, 100);
    check_eq("refr_t2.refr", 32'(refractory), 32'd0);
    cycle("post_refr", 1, 50, 0, 100);
    check_eq("post_refr.mem50", 32'(membrane), 32'd50);

    // Saturation: climb to 0xFFF0 then overflow twice.
    async_reset("sat");
    for (int i = 0; i < 256; i++) cycle("sat_climb", 1, 255, 0, MEM_MAX);
    cycle("sat_f0", 1, 240, 0, MEM_MAX);
    check_eq("sat.fff0", 32'(membrane), 32'hFFF0);
    cycle("sat_ff", 1, 255, 0, MEM_MAX);
    check_eq("sat.ffff_a", 32'(membrane), 32'hFFFF);
    cycle("sat_01", 1, 1, 0, MEM_MAX);
    check_eq("sat.ffff_b", 32'(membrane), 32'hFFFF);
    // Saturated potential must fire even against the maximum threshold.
    cycle("sat_fire", 0, 0, 1, MEM_MAX);
    check_eq("sat_fire.spike", 32'(spike_out), 32'd1);

    // threshold = 0 fires on every INTEG tick, including back-to-back ticks.
    async_reset("thr0");
    for (int i = 0; i < 8; i++) cycle("thr0", 0, 0, 1, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      int v, s, t, th;
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s  = $urandom_range(0, 255);
      t  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      case ($urandom_range(0, 9))
        0:       th = 0;
        1:       th = $urandom_range(0, MEM_MAX);
        default: th = $urandom_range(1, 700);
      endcase
      cycle("rand", v, s, t, th);
      if (i % 1000 == 999) async_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
